// File: rtl/radix_four_booth_pkg.sv
// radix_four_booth_pkg: shared FSM states, Booth digit field positions and iteration count.
package radix_four_booth_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int DIGIT_NON   = 2;
  localparam int DIGIT_SIGN  = 1;
  localparam int DIGIT_POWER = 0;
  function automatic int booth_iterations(input int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_digit_recoder.sv
// booth_digit_recoder: radix-4 Booth window {m[2i+1], m[2i], m[2i-1]} to {non, sign, power} digit.
module booth_digit_recoder
  import radix_four_booth_pkg::*;
(
  input  logic [2:0] window_in,
  output logic [2:0] digit_out
);
  always_comb begin
    digit_out = '0;
    digit_out[DIGIT_NON]   = window_in == 3'b000 || window_in == 3'b111;
    digit_out[DIGIT_SIGN]  = window_in[2] & ~(window_in[1] & window_in[0]);
    digit_out[DIGIT_POWER] = window_in == 3'b011 || window_in == 3'b100;
  end
endmodule

// File: rtl/radix_four_booth_multiplier.sv
// radix_four_booth_multiplier: iterative radix-4 Booth sign/magnitude multiplier, 2 bits per cycle.
// Optional RADIX_FOUR_BOOTH_MULTIPLIER_ZERO_SKIP_EN finishes after one cycle when an operand is 0.
module radix_four_booth_multiplier
  import radix_four_booth_pkg::*;
#(
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int NUM_RADIX             = 4
) (
  input  logic                               clk_in,
  input  logic                               reset_in,
  input  logic                               request_valid_in,
  output logic                               request_ack_out,
  input  logic                               multiplicand_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0]   multiplicand_in,
  input  logic                               multiplier_sign_in,
  input  logic [OPERAND_WIDTH_IN_BITS-1:0]   multiplier_in,
  output logic                               product_valid_out,
  input  logic                               product_ack_in,
  output logic                               product_sign_out,
  output logic [2*OPERAND_WIDTH_IN_BITS-1:0] product_out
);
  localparam int W  = OPERAND_WIDTH_IN_BITS;
  localparam int N  = booth_iterations(W);
  localparam int CW = $clog2(N);

  if (NUM_RADIX != 4 || W % 2 != 0 || W < 4) begin : g_bad_cfg
    $error("radix_four_booth_multiplier: unsupported configuration");
  end

  logic [1:0]     state_q, state_d;
  logic           ack_q, ack_d, valid_q, valid_d;
  logic [W+2:0]   hi_q, hi_d;
  logic [W+1:0]   lo_q, lo_d;
  logic           prev_q, prev_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic           sign_q, sign_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*W-1:0] product_q, product_d;
  logic           psign_q, psign_d;
  logic [2:0]     digit;
  logic [W+2:0]   x_ext, mag, addend, sum, hi_sh;
  logic [W+1:0]   lo_sh;
  logic [2*W-1:0] full, result;
  logic           run, transfer, last;

  booth_digit_recoder u_recoder (
    .window_in (
      {lo_q[1:0], prev_q}),
    .digit_out (digit)
  );

  assign run      = state_q == RUN;
  assign transfer = state_q == IDLE && ack_q && request_valid_in;

  // {hi, lo} is shifted as one register: product bits migrate from hi into lo as multiplier bits retire.
  always_comb begin
    x_ext  = {3'b000, mcand_q};
    mag    = digit[DIGIT_POWER] ? x_ext << 1 : x_ext;
    addend = digit[DIGIT_NON] ? '0 : digit[DIGIT_SIGN] ? -mag : mag;
    sum    = hi_q + addend;
    hi_sh  = {{2{sum[W+2]}}, sum[W+2:2]};
    lo_sh  = {sum[1:0], lo_q[W+1:2]};
    full   = {hi_sh[W-3:0], lo_sh};
  end

`ifdef RADIX_FOUR_BOOTH_MULTIPLIER_ZERO_SKIP_EN
  logic zero_q, zero_d;
  // A zero operand spends a single RUN cycle so the result still appears one edge after the transfer.
  assign last   = run && (count_q == CW'(N - 1) || zero_q);
  assign result = zero_q ? '0 : full;
  always_comb zero_d = transfer ? (multiplicand_in == '0 || multiplier_in == '0) : zero_q;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) zero_q <= 1'b0;
    else          zero_q <= zero_d;
`else
  assign last   = run && count_q == CW'(N - 1);
  assign result = full;
`endif

  always_comb begin
    state_d   = transfer ? RUN : last ? DONE : (state_q == DONE && product_ack_in) ? IDLE : state_q;
    ack_d     = state_d == IDLE;
    valid_d   = state_d == DONE;
    hi_d      = transfer ? '0 : run ? hi_sh : hi_q;
    lo_d      = transfer ? {2'b00, multiplier_in} : run ? lo_sh : lo_q;
    prev_d    = transfer ? 1'b0 : run ? lo_q[1] : prev_q;
    count_d   = transfer ? '0 : run ? count_q + 1'b1 : count_q;
    mcand_d   = transfer ? multiplicand_in : mcand_q;
    sign_d    = transfer ? multiplicand_sign_in ^ multiplier_sign_in : sign_q;
    product_d = last ? result : product_q;
    psign_d   = last ? sign_q & (|result) : psign_q;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      ack_q     <= 1'b0;
      valid_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      prev_q    <= 1'b0;
      mcand_q   <= '0;
      sign_q    <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      psign_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      prev_q    <= prev_d;
      mcand_q   <= mcand_d;
      sign_q    <= sign_d;
      count_q   <= count_d;
      product_q <= product_d;
      psign_q   <= psign_d;
    end
  end

  assign request_ack_out   = ack_q;
  assign product_valid_out = valid_q;
  assign product_sign_out  = psign_q;
  assign product_out       = product_q;
endmodule

// File: tb/tb_radix_four_booth_multiplier.sv
// tb_radix_four_booth_multiplier: directed and random checks of the Booth multiplier against plain arithmetic.
module tb_radix_four_booth_multiplier;
  localparam int W = 64;
  localparam int N = W / 2 + 1;
`ifdef RADIX_FOUR_BOOTH_MULTIPLIER_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = N;
`endif

  logic           clk = 1'b0;
  logic           reset_in = 1'b1;
  logic           request_valid_in = 1'b0;
  logic           request_ack_out;
  logic           multiplicand_sign_in = 1'b0;
  logic [W-1:0]   multiplicand_in = '0;
  logic           multiplier_sign_in = 1'b0;
  logic [W-1:0]   multiplier_in = '0;
  logic           product_valid_out;
  logic           product_ack_in = 1'b0;
  logic           product_sign_out;
  logic [2*W-1:0] product_out;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  radix_four_booth_multiplier #(.OPERAND_WIDTH_IN_BITS(W), .NUM_RADIX(4)) dut (
    .clk_in               (clk),
    .reset_in             (reset_in),
    .request_valid_in     (request_valid_in),
    .request_ack_out      (request_ack_out),
    .multiplicand_sign_in (multiplicand_sign_in),
    .multiplicand_in      (multiplicand_in),
    .multiplier_sign_in   (multiplier_sign_in),
    .multiplier_in        (multiplier_in),
    .product_valid_out    (product_valid_out),
    .product_ack_in       (product_ack_in),
    .product_sign_out     (product_sign_out),
    .product_out          (product_out)
  );

  function automatic logic [2*W-1:0] ref_mag(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic logic ref_sign(input logic sa, input logic [W-1:0] a, input logic sb, input logic [W-1:0] b);
    return (sa ^ sb) && a != '0 && b != '0;
  endfunction

  task automatic start_op(input logic sa, input logic [W-1:0] a, input logic sb, input logic [W-1:0] b);
    int c = 0;
    while (!request_ack_out && c < 50) begin
      @(posedge clk); #1; c++;
    end
    multiplicand_sign_in = sa;
    multiplicand_in      = a;
    multiplier_sign_in   = sb;
    multiplier_in        = b;
    request_valid_in     = 1'b1;
    @(posedge clk); #1;
    request_valid_in     = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!product_valid_out && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic ack_result();
    product_ack_in = 1'b1;
    @(posedge clk); #1;
    product_ack_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 4;
    if (request_ack_out !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", request_ack_out); end
    if (product_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", product_valid_out); end
    if (product_sign_out !== 1'b0) begin n_err++; $display("FAIL reset_sign got %b want 0", product_sign_out); end
    if (product_out !== '0) begin n_err++; $display("FAIL reset_product got %h want 0", product_out); end
    reset_in = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (request_ack_out !== 1'b1) begin n_err++; $display("FAIL ack_after_release got %b want 1", request_ack_out); end
  endtask

  task automatic test_basic();
    int lat;
    start_op(1'b0, 64'd3, 1'b0, 64'd5);
    n_cmp++;
    if (request_ack_out !== 1'b0) begin n_err++; $display("FAIL ack_falls got %b want 0", request_ack_out); end
    wait_done(lat);
    n_cmp += 3;
    if (lat != N) begin n_err++; $display("FAIL basic_latency got %0d want %0d", lat, N); end
    if (product_out !== 128'd15) begin n_err++; $display("FAIL basic_product got %h want 15", product_out); end
    if (product_sign_out !== 1'b0) begin n_err++; $display("FAIL basic_sign got %b want 0", product_sign_out); end
    ack_result();
    n_cmp += 3;
    if (product_valid_out !== 1'b0) begin n_err++; $display("FAIL valid_after_ack got %b want 0", product_valid_out); end
    if (request_ack_out !== 1'b1) begin n_err++; $display("FAIL ack_after_done got %b want 1", request_ack_out); end
    if (product_out !== 128'd15) begin n_err++; $display("FAIL product_held got %h want 15", product_out); end
  endtask

  task automatic test_max();
    int lat;
    start_op(1'b1, '1, 1'b0, '1);
    wait_done(lat);
    n_cmp += 4;
    if (lat != N) begin n_err++; $display("FAIL max_latency got %0d want %0d", lat, N); end
    if (product_out[2*W-1:W] !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL max_high got %h want fffffffffffffffe", product_out[2*W-1:W]); end
    if (product_out[W-1:0] !== 64'h1) begin n_err++; $display("FAIL max_low got %h want 1", product_out[W-1:0]); end
    if (product_sign_out !== 1'b1) begin n_err++; $display("FAIL max_sign got %b want 1", product_sign_out); end
    ack_result();
  endtask

  task automatic test_zero();
    int lat;
    start_op(1'b1, 64'd0, 1'b0, 64'h1234);
    wait_done(lat);
    n_cmp += 3;
    if (lat != ZLAT) begin n_err++; $display("FAIL zero_latency got %0d want %0d", lat, ZLAT); end
    if (product_out !== '0) begin n_err++; $display("FAIL zero_product got %h want 0", product_out); end
    if (product_sign_out !== 1'b0) begin n_err++; $display("FAIL zero_sign got %b want 0", product_sign_out); end
    ack_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] aa;
    start_op(1'b0, 64'd5, 1'b1, 64'd7);
    wait_done(lat);
    multiplicand_in  = 64'h99;
    multiplier_in    = 64'h99;
    request_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp += 4;
      if (product_valid_out !== 1'b1) begin n_err++; $display("FAIL hold_valid cyc %0d got %b want 1", i, product_valid_out); end
      if (request_ack_out !== 1'b0) begin n_err++; $display("FAIL hold_ack cyc %0d got %b want 0", i, request_ack_out); end
      if (product_out !== 128'd35) begin n_err++; $display("FAIL hold_product cyc %0d got %h want 35", i, product_out); end
      if (product_sign_out !== 1'b1) begin n_err++; $display("FAIL hold_sign cyc %0d got %b want 1", i, product_sign_out); end
    end
    request_valid_in = 1'b0;
    ack_result();
    n_cmp++;
    if (request_ack_out !== 1'b1) begin n_err++; $display("FAIL no_second_accept ack got %b want 1", request_ack_out); end
    aa = {32{2'b10}};
    start_op(1'b0, aa, 1'b0, 64'd2);
    wait_done(lat);
    n_cmp += 2;
    if (product_out !== {63'd0, 1'b1, {31{2'b01}}, 2'b00}) begin n_err++; $display("FAIL aa_times_2 got %h want 15555555555555554", product_out); end
    if (lat != N) begin n_err++; $display("FAIL aa_latency got %0d want %0d", lat, N); end
    ack_result();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(1'b1, 64'h123, 1'b0, 64'h456);
    repeat (10) @(posedge clk);
    #1;
    reset_in = 1'b1;
    #1;
    n_cmp += 4;
    if (request_ack_out !== 1'b0) begin n_err++; $display("FAIL midrst_ack got %b want 0", request_ack_out); end
    if (product_valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", product_valid_out); end
    if (product_sign_out !== 1'b0) begin n_err++; $display("FAIL midrst_sign got %b want 0", product_sign_out); end
    if (product_out !== '0) begin n_err++; $display("FAIL midrst_product got %h want 0", product_out); end
    @(posedge clk); #1;
    reset_in = 1'b0;
    start_op(1'b0, 64'd7, 1'b0, 64'd9);
    wait_done(lat);
    n_cmp += 3;
    if (lat != N) begin n_err++; $display("FAIL post_reset_latency got %0d want %0d", lat, N); end
    if (product_out !== 128'd63) begin n_err++; $display("FAIL post_reset_product got %h want 63", product_out); end
    if (product_sign_out !== 1'b0) begin n_err++; $display("FAIL post_reset_sign got %b want 0", product_sign_out); end
    ack_result();
  endtask

  task automatic test_random();
    logic [W-1:0] pats [6];
    logic [W-1:0] a, b;
    logic [2*W-1:0] em;
    logic sa, sb, es;
    int lat, el;
    pats[0] = {32{2'b01}};
    pats[1] = {32{2'b10}};
    pats[2] = 64'd1;
    pats[3] = 64'h8000_0000_0000_0000;
    pats[4] = '1;
    pats[5] = '0;
    for (int i = 0; i < 1000; i++) begin
      a  = ($urandom_range(3) == 0) ? pats[$urandom_range(5)] : {$urandom, $urandom};
      b  = ($urandom_range(3) == 0) ? pats[$urandom_range(5)] : {$urandom, $urandom};
      sa = 1'($urandom_range(1));
      sb = 1'($urandom_range(1));
      em = ref_mag(a, b);
      es = ref_sign(sa, a, sb, b);
      el = (a == '0 || b == '0) ? ZLAT : N;
      start_op(sa, a, sb, b);
      wait_done(lat);
      n_cmp += 3;
      if (lat != el) begin n_err++; $display("FAIL rand_latency %0d got %0d want %0d", i, lat, el); end
      if (product_out !== em) begin n_err++; $display("FAIL rand_product %0d a=%h b=%h got %h want %h", i, a, b, product_out, em); end
      if (product_sign_out !== es) begin n_err++; $display("FAIL rand_sign %0d got %b want %b", i, product_sign_out, es); end
      ack_result();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
